// File: rtl/eth_vlg_rto.sv
// eth_vlg_rto: retransmission timer with exponential backoff; tick/arm/ack in, timeout/fail/busy/retry_cnt/rto_cur out
module eth_vlg_rto #(
  parameter int RTO_INIT = 8,
  parameter int RTO_MAX  = 64,
  parameter int RETRIES  = 4
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           arm,
  input  logic                           ack,
  output logic                           timeout,
  output logic                           fail,
  output logic                           busy,
  output logic [$clog2(RETRIES+1)-1:0]   retry_cnt,
  output logic [$clog2(RTO_MAX+1)-1:0]   rto_cur
);
  localparam int RW = $clog2(RETRIES+1);
  localparam int TW = $clog2(RTO_MAX+1);
  localparam logic [TW-1:0] INIT = TW'(RTO_INIT);
  localparam logic [TW:0] MAX = (TW+1)'(RTO_MAX);
  typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;
  state_t state, state_n;
  logic [TW-1:0] elapsed, elapsed_n, rto_n;
  logic [RW-1:0] retry_n;
  logic [TW:0] rto_dbl;
  logic timeout_n;
  assign rto_dbl = {rto_cur, 1'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elapsed   <= '0;
      rto_cur   <= INIT;
      retry_cnt <= '0;
      timeout   <= 1'b0;
      fail      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      elapsed   <= elapsed_n;
      rto_cur   <= rto_n;
      retry_cnt <= retry_n;
      timeout   <= timeout_n;
      fail      <= state_n == FAIL;
      busy      <= state_n == RUN;
    end
  end
  always_comb begin
    state_n   = state;
    elapsed_n = elapsed;
    rto_n     = rto_cur;
    retry_n   = retry_cnt;
    timeout_n = 1'b0;
    if (ack || arm) begin
      state_n   = ack ? IDLE : RUN;
      elapsed_n = '0;
      rto_n     = INIT;
      retry_n   = '0;
    end else if (state == RUN && tick) begin
      if (elapsed != rto_cur - 1'b1) begin
        elapsed_n = elapsed + 1'b1;
      end else if (retry_cnt < RW'(RETRIES)) begin
        timeout_n = 1'b1;
        retry_n   = retry_cnt + 1'b1;
        rto_n     = rto_dbl > MAX ? MAX[TW-1:0] : rto_dbl[TW-1:0];
        elapsed_n = '0;
      end else begin
        state_n = FAIL;
      end
    end
  end
endmodule

// File: tb/tb_eth_vlg_rto.sv
// tb_eth_vlg_rto: directed self-checking bench for eth_vlg_rto (INIT=2/MAX=8/RETRIES=2 and INIT=2/MAX=4/RETRIES=3)
module tb_eth_vlg_rto;
  logic clk = 1'b0;
  logic rst, tick, arm, ack;
  logic to1, f1, b1;
  logic [1:0] rc1;
  logic [3:0] rt1;
  logic to2, f2, b2;
  logic [1:0] rc2;
  logic [2:0] rt2;
  int checks = 0;
  int failures = 0;
  int p1 = 0;
  int p2 = 0;
  always #5 clk = ~clk;
  eth_vlg_rto #(.RTO_INIT(2), .RTO_MAX(8), .RETRIES(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .arm(arm), .ack(ack),
    .timeout(to1), .fail(f1), .busy(b1), .retry_cnt(rc1), .rto_cur(rt1)
  );
  eth_vlg_rto #(.RTO_INIT(2), .RTO_MAX(4), .RETRIES(3)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .arm(arm), .ack(ack),
    .timeout(to2), .fail(f2), .busy(b2), .retry_cnt(rc2), .rto_cur(rt2)
  );
  task automatic cyc(input logic r, input logic t, input logic a, input logic k);
    rst = r;
    tick = t;
    arm = a;
    ack = k;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick = 1'b0;
    arm = 1'b0;
    ack = 1'b0;
    if (to1) p1++;
    if (to2) p2++;
  endtask
  task automatic tick_period();
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
  endtask
  task automatic test_reset();
    cyc(1, 1, 1, 0);
    cyc(1, 0, 1, 1);
    checks++;
    if (to1 !== 1'b0 || f1 !== 1'b0 || b1 !== 1'b0 || rc1 !== 2'd0 || rt1 !== 4'd2 || rt2 !== 3'd2) begin
      failures++;
      $display("FAIL reset: to=%0b fail=%0b busy=%0b retry=%0d rto=%0d rto2=%0d expected 0 0 0 0 2 2", to1, f1, b1, rc1, rt1, rt2);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    checks++;
    if (to1 !== 1'b0 || f1 !== 1'b0 || b1 !== 1'b0 || rc1 !== 2'd0 || rt1 !== 4'd2) begin
      failures++;
      $display("FAIL idle_ack_tick: to=%0b fail=%0b busy=%0b retry=%0d rto=%0d expected 0 0 0 0 2", to1, f1, b1, rc1, rt1);
    end
  endtask
  task automatic test_backoff();
    int e_to, e_rto, e_rc, e_f;
    p1 = 0;
    cyc(0, 0, 1, 0);
    checks++;
    if (b1 !== 1'b1 || rt1 !== 4'd2 || rc1 !== 2'd0) begin
      failures++;
      $display("FAIL backoff_arm: busy=%0b rto=%0d retry=%0d expected 1 2 0", b1, rt1, rc1);
    end
    for (int n = 1; n <= 14; n++) begin
      cyc(0, 1, 0, 0);
      e_to = (n == 2 || n == 6) ? 1 : 0;
      e_rto = n < 2 ? 2 : n < 6 ? 4 : 8;
      e_rc = n < 2 ? 0 : n < 6 ? 1 : 2;
      e_f = n >= 14 ? 1 : 0;
      checks++;
      if (to1 !== e_to[0] || rt1 !== e_rto[3:0] || rc1 !== e_rc[1:0] || f1 !== e_f[0]) begin
        failures++;
        $display("FAIL backoff_tick%0d: to=%0b rto=%0d retry=%0d fail=%0b expected %0d %0d %0d %0d", n, to1, rt1, rc1, f1, e_to, e_rto, e_rc, e_f);
      end
      repeat (3) cyc(0, 0, 0, 0);
    end
    checks++;
    if (p1 != 2 || b1 !== 1'b0 || f1 !== 1'b1 || rc1 !== 2'd2) begin
      failures++;
      $display("FAIL backoff_end: pulses=%0d busy=%0b fail=%0b retry=%0d expected 2 0 1 2", p1, b1, f1, rc1);
    end
    tick_period();
    tick_period();
    checks++;
    if (p1 != 2 || f1 !== 1'b1 || rt1 !== 4'd8 || rc1 !== 2'd2) begin
      failures++;
      $display("FAIL fail_hold: pulses=%0d fail=%0b rto=%0d retry=%0d expected 2 1 8 2", p1, f1, rt1, rc1);
    end
  endtask
  task automatic test_saturation();
    int e_to, e_rto, e_rc, e_f;
    p2 = 0;
    cyc(0, 0, 1, 0);
    for (int n = 1; n <= 14; n++) begin
      cyc(0, 1, 0, 0);
      e_to = (n == 2 || n == 6 || n == 10) ? 1 : 0;
      e_rto = n < 2 ? 2 : 4;
      e_rc = n < 2 ? 0 : n < 6 ? 1 : n < 10 ? 2 : 3;
      e_f = n >= 14 ? 1 : 0;
      checks++;
      if (to2 !== e_to[0] || rt2 !== e_rto[2:0] || rc2 !== e_rc[1:0] || f2 !== e_f[0]) begin
        failures++;
        $display("FAIL sat_tick%0d: to=%0b rto=%0d retry=%0d fail=%0b expected %0d %0d %0d %0d", n, to2, rt2, rc2, f2, e_to, e_rto, e_rc, e_f);
      end
      repeat (3) cyc(0, 0, 0, 0);
    end
    checks++;
    if (p2 != 3 || b2 !== 1'b0 || f2 !== 1'b1) begin
      failures++;
      $display("FAIL sat_end: pulses=%0d busy=%0b fail=%0b expected 3 0 1", p2, b2, f2);
    end
  endtask
  task automatic test_ack_before_expiry();
    p1 = 0;
    cyc(0, 0, 1, 0);
    tick_period();
    cyc(0, 0, 0, 1);
    checks++;
    if (b1 !== 1'b0 || to1 !== 1'b0 || rt1 !== 4'd2 || rc1 !== 2'd0 || f1 !== 1'b0) begin
      failures++;
      $display("FAIL ack_idle: busy=%0b to=%0b rto=%0d retry=%0d fail=%0b expected 0 0 2 0 0", b1, to1, rt1, rc1, f1);
    end
    repeat (3) tick_period();
    checks++;
    if (p1 != 0 || b1 !== 1'b0) begin
      failures++;
      $display("FAIL ack_quiet: pulses=%0d busy=%0b expected 0 0", p1, b1);
    end
  endtask
  task automatic test_simultaneous();
    cyc(0, 1, 1, 0);
    checks++;
    if (b1 !== 1'b1 || rt1 !== 4'd2) begin
      failures++;
      $display("FAIL arm_tick: busy=%0b rto=%0d expected 1 2", b1, rt1);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (to1 !== 1'b0) begin
      failures++;
      $display("FAIL arm_tick_first: to=%0b expected 0", to1);
    end
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    checks++;
    if (to1 !== 1'b1 || rt1 !== 4'd4 || rc1 !== 2'd1) begin
      failures++;
      $display("FAIL arm_tick_second: to=%0b rto=%0d retry=%0d expected 1 4 1", to1, rt1, rc1);
    end
    cyc(0, 1, 1, 1);
    checks++;
    if (b1 !== 1'b0 || to1 !== 1'b0 || rt1 !== 4'd2 || rc1 !== 2'd0) begin
      failures++;
      $display("FAIL ack_arm_tick: busy=%0b to=%0b rto=%0d retry=%0d expected 0 0 2 0", b1, to1, rt1, rc1);
    end
  endtask
  task automatic test_rearm_after_fail();
    cyc(0, 0, 1, 0);
    repeat (14) tick_period();
    checks++;
    if (f1 !== 1'b1) begin
      failures++;
      $display("FAIL rearm_pre: fail=%0b expected 1", f1);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (f1 !== 1'b0 || b1 !== 1'b1 || rc1 !== 2'd0 || rt1 !== 4'd2) begin
      failures++;
      $display("FAIL rearm: fail=%0b busy=%0b retry=%0d rto=%0d expected 0 1 0 2", f1, b1, rc1, rt1);
    end
  endtask
  task automatic test_reset_mid();
    cyc(0, 0, 1, 0);
    repeat (3) tick_period();
    checks++;
    if (rc1 !== 2'd1 || rt1 !== 4'd4 || b1 !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: retry=%0d rto=%0d busy=%0b expected 1 4 1", rc1, rt1, b1);
    end
    p1 = 0;
    cyc(1, 1, 0, 0);
    checks++;
    if (to1 !== 1'b0 || f1 !== 1'b0 || b1 !== 1'b0 || rc1 !== 2'd0 || rt1 !== 4'd2) begin
      failures++;
      $display("FAIL rst_mid: to=%0b fail=%0b busy=%0b retry=%0d rto=%0d expected 0 0 0 0 2", to1, f1, b1, rc1, rt1);
    end
    repeat (4) tick_period();
    checks++;
    if (p1 != 0 || b1 !== 1'b0 || f1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_quiet: pulses=%0d busy=%0b fail=%0b expected 0 0 0", p1, b1, f1);
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if (b1 !== 1'b1 || rt1 !== 4'd2) begin
      failures++;
      $display("FAIL arm_after_rst: busy=%0b rto=%0d expected 1 2", b1, rt1);
    end
  endtask
  initial begin
    rst = 1'b1;
    tick = 1'b0;
    arm = 1'b0;
    ack = 1'b0;
    test_reset();
    test_backoff();
    test_saturation();
    test_ack_before_expiry();
    test_simultaneous();
    test_rearm_after_fail();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
